// File: rtl/core_hazard_ctrl_pkg.sv
// Shared encodings for the KayRV32 hazard/event controller: forward selects, FSM states, event bits.
// No logic; no latency.
// No flow control.
package core_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_MA = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_HALT    = 2'd2
    } hz_state_t;

    // Event bus bit positions for the default four-bit bus; IF is always the top bit.
    localparam int EV_WB = 0;
    localparam int EV_MA = 1;
    localparam int EV_EX = 2;
    localparam int EV_IF = 3;

endpackage

// File: rtl/core_fwd_sel.sv
// Per-operand forwarding comparator: picks MA result, then WB result, else register file.
// Combinational, zero latency.
// No flow control.
module core_fwd_sel
    import core_hazard_ctrl_pkg::*;
#(
    parameter int RF_ADDR_W = 5
) (
    input  logic [RF_ADDR_W-1:0] rs_addr,
    input  logic                 ma_wr_en,
    input  logic [RF_ADDR_W-1:0] ma_rd_addr,
    input  logic                 wb_wr_en,
    input  logic [RF_ADDR_W-1:0] wb_rd_addr,
    output logic [1:0]           fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (ma_wr_en && (ma_rd_addr != '0) && (ma_rd_addr == rs_addr)) begin
            fwd_sel = FWD_MA;
        end else if (wb_wr_en && (wb_rd_addr != '0) && (wb_rd_addr == rs_addr)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/core_hazard_ctrl.sv
// Pipeline hazard/event controller: forwarding selects, load-use stalls, branch flushes, halting events.
// Stall/flush/forward are same-cycle combinational; o_Interrupt/o_Cause register one cycle after the event.
// Stages hold while o_StallEn is high; HALT holds until acknowledged (sticky) or for one cycle.
module core_hazard_ctrl
    import core_hazard_ctrl_pkg::*;
#(
    parameter int RF_ADDR_W  = 5,
    parameter int EVENT_W    = 4,
    parameter int LOAD_LAT   = 1,
    parameter int IRQ_STICKY = 1
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic [EVENT_W-1:0]           i_EventBus,
    input  logic                         i_IRQ_Ack,
    input  logic [RF_ADDR_W-1:0]         i_ID_rs1_Addr,
    input  logic [RF_ADDR_W-1:0]         i_ID_rs2_Addr,
    input  logic                         i_ID_rs1_Used,
    input  logic                         i_ID_rs2_Used,
    input  logic [RF_ADDR_W-1:0]         i_EX_rs1_Addr,
    input  logic [RF_ADDR_W-1:0]         i_EX_rs2_Addr,
    input  logic                         i_EX_rd_wr_En,
    input  logic                         i_EX_Load_En,
    input  logic [RF_ADDR_W-1:0]         i_EX_rd_Addr,
    input  logic                         i_MA_rd_wr_En,
    input  logic                         i_MA_Store_En,
    input  logic [RF_ADDR_W-1:0]         i_MA_rd_Addr,
    input  logic [RF_ADDR_W-1:0]         i_MA_rs2_Addr,
    input  logic                         i_WB_rd_wr_En,
    input  logic [RF_ADDR_W-1:0]         i_WB_rd_Addr,
    input  logic                         i_EX_Branch_En,
    output logic [1:0]                   o_forward_op1,
    output logic [1:0]                   o_forward_op2,
    output logic                         o_forward_opM,
    output logic                         o_StallEn,
    output logic                         o_FlushEn_IFID,
    output logic                         o_FlushEn_EX,
    output logic                         o_Interrupt,
    output logic [$clog2(EVENT_W)-1:0]   o_Cause,
    output logic                         o_Stall
);

    localparam int CNT_W   = $clog2(LOAD_LAT + 1);
    localparam int CAUSE_W = $clog2(EVENT_W);

    hz_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic               event_any;
    logic               load_use;
    logic [CAUSE_W-1:0] event_idx;

    core_fwd_sel #(.RF_ADDR_W(RF_ADDR_W)) u_fwd_op1 (
        .rs_addr    (i_EX_rs1_Addr),
        .ma_wr_en   (i_MA_rd_wr_En),
        .ma_rd_addr (i_MA_rd_Addr),
        .wb_wr_en   (i_WB_rd_wr_En),
        .wb_rd_addr (i_WB_rd_Addr),
        .fwd_sel    (o_forward_op1)
    );

    core_fwd_sel #(.RF_ADDR_W(RF_ADDR_W)) u_fwd_op2 (
        .rs_addr    (i_EX_rs2_Addr),
        .ma_wr_en   (i_MA_rd_wr_En),
        .ma_rd_addr (i_MA_rd_Addr),
        .wb_wr_en   (i_WB_rd_wr_En),
        .wb_rd_addr (i_WB_rd_Addr),
        .fwd_sel    (o_forward_op2)
    );

    assign o_forward_opM = i_MA_Store_En && i_WB_rd_wr_En && (i_WB_rd_Addr != '0)
                           && (i_WB_rd_Addr == i_MA_rs2_Addr);

    assign event_any = |i_EventBus;

    assign load_use = i_EX_Load_En && i_EX_rd_wr_En && (i_EX_rd_Addr != '0)
                      && (((i_EX_rd_Addr == i_ID_rs1_Addr) && i_ID_rs1_Used)
                          || ((i_EX_rd_Addr == i_ID_rs2_Addr) && i_ID_rs2_Used));

    // Highest set bit wins the cause.
    always_comb begin
        event_idx = '0;
        for (int i = 0; i < EVENT_W; i++) begin
            if (i_EventBus[i]) event_idx = CAUSE_W'(i);
        end
    end

    // A taken event flushes everything, including out of a load stall.
    always_comb begin
        o_StallEn      = 1'b0;
        o_FlushEn_IFID = 1'b0;
        o_FlushEn_EX   = 1'b0;
        if (!i_Rst) begin
            case (state)
                ST_RUN: begin
                    if (event_any) begin
                        o_StallEn      = 1'b1;
                        o_FlushEn_IFID = 1'b1;
                        o_FlushEn_EX   = 1'b1;
                    end else if (i_EX_Branch_En) begin
                        o_FlushEn_IFID = 1'b1;
                        o_FlushEn_EX   = 1'b1;
                    end else if (load_use) begin
                        o_StallEn    = 1'b1;
                        o_FlushEn_EX = 1'b1;
                    end
                end
                ST_LDSTALL: begin
                    o_StallEn      = 1'b1;
                    o_FlushEn_EX   = 1'b1;
                    o_FlushEn_IFID = event_any;
                end
                ST_HALT: begin
                    o_StallEn      = 1'b1;
                    o_FlushEn_IFID = 1'b1;
                    o_FlushEn_EX   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_Stall = o_StallEn;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            o_Interrupt <= 1'b0;
            o_Cause     <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (event_any) begin
                        state       <= ST_HALT;
                        cnt         <= '0;
                        o_Interrupt <= 1'b1;
                        o_Cause     <= event_idx;
                    end else if (!i_EX_Branch_En && load_use && (LOAD_LAT > 1)) begin
                        state <= ST_LDSTALL;
                        cnt   <= CNT_W'(LOAD_LAT - 1);
                    end
                end
                ST_LDSTALL: begin
                    if (event_any) begin
                        state       <= ST_HALT;
                        cnt         <= '0;
                        o_Interrupt <= 1'b1;
                        o_Cause     <= event_idx;
                    end else if (cnt == CNT_W'(1)) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HALT: begin
                    if ((IRQ_STICKY == 0) || i_IRQ_Ack) begin
                        state       <= ST_RUN;
                        o_Interrupt <= 1'b0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Bench for core_hazard_ctrl: two instances (LOAD_LAT=3 sticky, LOAD_LAT=4 pulse) on shared inputs,
// compared every cycle against a remaining-stall-cycles reference model.
module tb_core_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ev;
    logic       ack, br;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ma_rd, ma_rs2, wb_rd;
    logic       id_u1, id_u2, ex_wr, ex_ld, ma_wr, ma_st, wb_wr;

    logic [1:0] a_op1, a_op2, b_op1, b_op2, a_cause, b_cause;
    logic       a_opm, a_stall, a_fifid, a_fex, a_irq, a_ostall;
    logic       b_opm, b_stall, b_fifid, b_fex, b_irq, b_ostall;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state per instance: halted flag, stall cycles still owed, interrupt, cause.
    bit m_halt[2];
    int m_left[2];
    bit m_irq[2];
    int m_cause[2];
    int m_lat[2]    = '{3, 4};
    bit m_sticky[2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    core_hazard_ctrl #(.RF_ADDR_W(5), .EVENT_W(4), .LOAD_LAT(3), .IRQ_STICKY(1)) u_dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_EventBus(ev), .i_IRQ_Ack(ack),
        .i_ID_rs1_Addr(id_rs1), .i_ID_rs2_Addr(id_rs2), .i_ID_rs1_Used(id_u1), .i_ID_rs2_Used(id_u2),
        .i_EX_rs1_Addr(ex_rs1), .i_EX_rs2_Addr(ex_rs2), .i_EX_rd_wr_En(ex_wr), .i_EX_Load_En(ex_ld),
        .i_EX_rd_Addr(ex_rd), .i_MA_rd_wr_En(ma_wr), .i_MA_Store_En(ma_st), .i_MA_rd_Addr(ma_rd),
        .i_MA_rs2_Addr(ma_rs2), .i_WB_rd_wr_En(wb_wr), .i_WB_rd_Addr(wb_rd), .i_EX_Branch_En(br),
        .o_forward_op1(a_op1), .o_forward_op2(a_op2), .o_forward_opM(a_opm), .o_StallEn(a_stall),
        .o_FlushEn_IFID(a_fifid), .o_FlushEn_EX(a_fex), .o_Interrupt(a_irq), .o_Cause(a_cause),
        .o_Stall(a_ostall)
    );

    core_hazard_ctrl #(.RF_ADDR_W(5), .EVENT_W(4), .LOAD_LAT(4), .IRQ_STICKY(0)) u_dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_EventBus(ev), .i_IRQ_Ack(ack),
        .i_ID_rs1_Addr(id_rs1), .i_ID_rs2_Addr(id_rs2), .i_ID_rs1_Used(id_u1), .i_ID_rs2_Used(id_u2),
        .i_EX_rs1_Addr(ex_rs1), .i_EX_rs2_Addr(ex_rs2), .i_EX_rd_wr_En(ex_wr), .i_EX_Load_En(ex_ld),
        .i_EX_rd_Addr(ex_rd), .i_MA_rd_wr_En(ma_wr), .i_MA_Store_En(ma_st), .i_MA_rd_Addr(ma_rd),
        .i_MA_rs2_Addr(ma_rs2), .i_WB_rd_wr_En(wb_wr), .i_WB_rd_Addr(wb_rd), .i_EX_Branch_En(br),
        .o_forward_op1(b_op1), .o_forward_op2(b_op2), .o_forward_opM(b_opm), .o_StallEn(b_stall),
        .o_FlushEn_IFID(b_fifid), .o_FlushEn_EX(b_fex), .o_Interrupt(b_irq), .o_Cause(b_cause),
        .o_Stall(b_ostall)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int fwd_ref(input int rs);
        if (ma_wr && ma_rd != 0 && ma_rd == rs[4:0]) return 1;
        if (wb_wr && wb_rd != 0 && wb_rd == rs[4:0]) return 2;
        return 0;
    endfunction

    function automatic int top_event(input logic [3:0] e);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (e[i]) idx = i;
        return idx;
    endfunction

    task automatic clear_inputs();
        rst = 1'b0; ev = '0; ack = 1'b0; br = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_u1 = 1'b0; id_u2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_wr = 1'b0; ex_ld = 1'b0;
        ma_wr = 1'b0; ma_st = 1'b0; ma_rd = '0; ma_rs2 = '0;
        wb_wr = 1'b0; wb_rd = '0;
    endtask

    // Inputs are already driven (just after the rising edge); check mid-cycle, then advance the model.
    task automatic run_cycle();
        bit lu, e_any;
        int x_stall, x_fifid, x_fex;
        #4;
        lu = ex_ld && ex_wr && ex_rd != 0 &&
             ((ex_rd == id_rs1 && id_u1) || (ex_rd == id_rs2 && id_u2));
        e_any = (ev != 0);
        for (int k = 0; k < 2; k++) begin
            x_stall = 0; x_fifid = 0; x_fex = 0;
            if (rst) begin
            end else if (m_halt[k]) begin
                x_stall = 1; x_fifid = 1; x_fex = 1;
            end else if (m_left[k] > 0) begin
                x_stall = 1; x_fex = 1; x_fifid = e_any ? 1 : 0;
            end else if (e_any) begin
                x_stall = 1; x_fifid = 1; x_fex = 1;
            end else if (br) begin
                x_fifid = 1; x_fex = 1;
            end else if (lu) begin
                x_stall = 1; x_fex = 1;
            end
            if (k == 0) begin
                check_val("a_op1", 32'(a_op1), 32'(fwd_ref(int'(ex_rs1))));
                check_val("a_op2", 32'(a_op2), 32'(fwd_ref(int'(ex_rs2))));
                check_val("a_opM", 32'(a_opm), 32'(ma_st && wb_wr && wb_rd != 0 && wb_rd == ma_rs2));
                check_val("a_stall", 32'(a_stall), 32'(x_stall));
                check_val("a_ostall", 32'(a_ostall), 32'(x_stall));
                check_val("a_flush_ifid", 32'(a_fifid), 32'(x_fifid));
                check_val("a_flush_ex", 32'(a_fex), 32'(x_fex));
                check_val("a_irq", 32'(a_irq), 32'(m_irq[0]));
                check_val("a_cause", 32'(a_cause), 32'(m_cause[0]));
            end else begin
                check_val("b_op1", 32'(b_op1), 32'(fwd_ref(int'(ex_rs1))));
                check_val("b_op2", 32'(b_op2), 32'(fwd_ref(int'(ex_rs2))));
                check_val("b_opM", 32'(b_opm), 32'(ma_st && wb_wr && wb_rd != 0 && wb_rd == ma_rs2));
                check_val("b_stall", 32'(b_stall), 32'(x_stall));
                check_val("b_ostall", 32'(b_ostall), 32'(x_stall));
                check_val("b_flush_ifid", 32'(b_fifid), 32'(x_fifid));
                check_val("b_flush_ex", 32'(b_fex), 32'(x_fex));
                check_val("b_irq", 32'(b_irq), 32'(m_irq[1]));
                check_val("b_cause", 32'(b_cause), 32'(m_cause[1]));
            end
            if (rst) begin
                m_halt[k] = 0; m_left[k] = 0; m_irq[k] = 0; m_cause[k] = 0;
            end else if (m_halt[k]) begin
                if (!m_sticky[k] || ack) begin
                    m_halt[k] = 0; m_irq[k] = 0;
                end
            end else if (e_any) begin
                m_halt[k] = 1; m_left[k] = 0; m_irq[k] = 1; m_cause[k] = top_event(ev);
            end else if (m_left[k] > 0) begin
                m_left[k]--;
            end else if (!br && lu) begin
                m_left[k] = m_lat[k] - 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_halt[k] = 0; m_left[k] = 0; m_irq[k] = 0; m_cause[k] = 0;
        end
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        run_cycle(); run_cycle();
        rst = 1'b0;
        idle(2);

        // Forwarding: MA wins over WB, x0 never forwards.
        ma_wr = 1'b1; ma_rd = 5'd5; wb_wr = 1'b1; wb_rd = 5'd5; ex_rs1 = 5'd5;
        run_cycle();
        ma_rd = 5'd0; wb_rd = 5'd0;
        run_cycle();
        ma_wr = 1'b0; wb_rd = 5'd9; ex_rs2 = 5'd9; ma_st = 1'b1; ma_rs2 = 5'd9;
        run_cycle();
        clear_inputs();

        // Load-use on rs2 for one cycle, then drain the stall.
        ex_ld = 1'b1; ex_wr = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_u2 = 1'b1;
        run_cycle();
        clear_inputs();
        idle(5);

        // Branch and load-use together: branch wins.
        ex_ld = 1'b1; ex_wr = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_u1 = 1'b1; br = 1'b1;
        run_cycle();
        clear_inputs();
        idle(1);

        // Event 0110 -> cause 2; later events ignored; acknowledge releases.
        ev = 4'b0110;
        run_cycle();
        ev = 4'b1000;
        run_cycle();
        ev = '0;
        idle(1);
        ack = 1'b1;
        run_cycle();
        ack = 1'b0;
        idle(2);

        // Event during a load stall, then reset mid-HALT.
        ex_ld = 1'b1; ex_wr = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_u1 = 1'b1;
        run_cycle();
        clear_inputs();
        run_cycle();
        ev = 4'b0001;
        run_cycle();
        ev = '0;
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        idle(2);

        // Randomized traffic with small address range to provoke matches.
        for (int i = 0; i < 800; i++) begin
            rst    = ($urandom_range(0, 59) == 0);
            ev     = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            ack    = ($urandom_range(0, 3) == 0);
            br     = ($urandom_range(0, 5) == 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_u1  = 1'($urandom); id_u2 = 1'($urandom);
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            ex_wr  = ($urandom_range(0, 3) != 0); ex_ld = ($urandom_range(0, 2) == 0);
            ma_wr  = 1'($urandom); ma_st = 1'($urandom);
            ma_rd  = 5'($urandom_range(0, 3)); ma_rs2 = 5'($urandom_range(0, 3));
            wb_wr  = 1'($urandom); wb_rd = 5'($urandom_range(0, 3));
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
